core_l1_mem_arbiter: RTL and testbench

- Sits between the L1 data cache, the L1 instruction cache and the shared L2.
- Arbitrates L1D/L1I line-miss requests onto the single L2 request port, round-robin on ties.
- Routes the L2 response back to the granted requester.
- Sequences whole-hierarchy flushes: waits for both L1 flushes to complete, then issues a one-cycle L2 flush request.

---
 rtl/core_l1_arb_pkg.sv | 28 ++
 rtl/core_l1_mem_arbiter_flush_seq.sv | 70 +++++++
 rtl/core_l1_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_core_l1_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_l1_arb_pkg.sv
// -----------------------------------------------------------------------------
// core_l1_arb_pkg
// Shared types and default widths for the L1 -> L2 memory arbiter slice.
//   arb_state_t   : request arbiter states (IDLE / GNT_L1D / GNT_L1I)
//   flush_state_t : hierarchy flush sequencer states
//   *_W_DEF       : default address / line / opcode widths
// -----------------------------------------------------------------------------
package core_l1_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned OPC_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_L1D = 2'd1,
    GNT_L1I = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    FLUSH_IDLE       = 3'd0,
    WAIT_FOR_L1D_L1I = 3'd1,
    GOT_L1D          = 3'd2,
    GOT_L1I          = 3'd3,
    FLUSH_L2         = 3'd4
  } flush_state_t;

endpackage

// File: rtl/core_l1_mem_arbiter_flush_seq.sv
// -----------------------------------------------------------------------------
// l1_flush_seq
// Whole-hierarchy flush sequencer. Waits for both L1 flushes to report
// completion (a cache not asked to flush counts as already done), then emits a
// registered one-cycle L2 flush pulse. FLUSH_L2 is terminal until reset.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   flush_req_l1d_i/_l1i_i  : core flush requests
//   l1d/l1i_flush_cmpl_i    : one-cycle completion pulses from the L1s
//   in_flush_mode_o         : registered, high from the first non-idle state on
//   l2_flush_req_o          : registered one-cycle pulse on entry to FLUSH_L2
// -----------------------------------------------------------------------------
module l1_flush_seq
  import core_l1_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush_req_l1d_i,
  input  logic flush_req_l1i_i,
  input  logic l1d_flush_cmpl_i,
  input  logic l1i_flush_cmpl_i,
  output logic in_flush_mode_o,
  output logic l2_flush_req_o
);

  flush_state_t state_q, state_d;
  logic         in_flush_q, in_flush_d;
  logic         l2_flush_q, l2_flush_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FLUSH_IDLE;
      in_flush_q <= 1'b0;
      l2_flush_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_flush_q <= in_flush_d;
      l2_flush_q <= l2_flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        if (flush_req_l1d_i && flush_req_l1i_i) state_d = WAIT_FOR_L1D_L1I;
        else if (flush_req_l1i_i)               state_d = GOT_L1D;
        else if (flush_req_l1d_i)               state_d = GOT_L1I;
      end
      WAIT_FOR_L1D_L1I: begin
        if (l1d_flush_cmpl_i && l1i_flush_cmpl_i) state_d = FLUSH_L2;
        else if (l1d_flush_cmpl_i)                state_d = GOT_L1D;
        else if (l1i_flush_cmpl_i)                state_d = GOT_L1I;
      end
      GOT_L1D:  if (l1i_flush_cmpl_i) state_d = FLUSH_L2;
      GOT_L1I:  if (l1d_flush_cmpl_i) state_d = FLUSH_L2;
      FLUSH_L2: state_d = FLUSH_L2;
      default:  state_d = FLUSH_IDLE;
    endcase

    // Flush mode latches on entering any active state and never drops.
    in_flush_d = in_flush_q | (state_d != FLUSH_IDLE);
    // Pulse only on the transition into FLUSH_L2, not while sitting there.
    l2_flush_d = (state_d == FLUSH_L2) && (state_q != FLUSH_L2);
  end

  assign in_flush_mode_o = in_flush_q;
  assign l2_flush_req_o  = l2_flush_q;

endmodule

// File: rtl/core_l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_l1_mem_arbiter
// Arbitrates L1D and L1I line-miss requests onto the single L2 request port,
// routes the L2 response back to the granted cache, and sequences a whole
// hierarchy flush through l1_flush_seq.
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   l1d_req_* / l1i_req_*       : request strobes, address, opcode (+L1D data)
//   l1d_rsp_valid/l1i_rsp_valid : L2 response belongs to that cache (comb.)
//   l2_req_valid/ack/addr/...   : L2 request port (valid is registered)
//   l2_rsp_valid/load_data      : L2 response; data passed straight to L1s
//   flush_req_*, *_flush_complete, in_flush_mode, l2_flush_req : flush control
// Optional: define L1_ARB_TRACE_EN for simulation messages on each completed
// transfer (no effect on cycle behaviour).
// -----------------------------------------------------------------------------
module core_l1_mem_arbiter
  import core_l1_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l1d_req_valid,
  input  logic [ADDR_W-1:0] l1d_req_addr,
  input  logic [OPC_W-1:0]  l1d_req_opcode,
  input  logic [LINE_W-1:0] l1d_req_store_data,
  output logic              l1d_rsp_valid,
  input  logic              l1i_req_valid,
  input  logic [ADDR_W-1:0] l1i_req_addr,
  input  logic [OPC_W-1:0]  l1i_req_opcode,
  output logic              l1i_rsp_valid,
  output logic              l2_req_valid,
  input  logic              l2_req_ack,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [OPC_W-1:0]  l2_req_opcode,
  output logic [LINE_W-1:0] l2_req_store_data,
  input  logic              l2_rsp_valid,
  input  logic [LINE_W-1:0] l2_rsp_load_data,
  output logic [LINE_W-1:0] l1_rsp_load_data,
  input  logic              flush_req_l1d,
  input  logic              flush_req_l1i,
  input  logic              l1d_flush_complete,
  input  logic              l1i_flush_complete,
  output logic              in_flush_mode,
  output logic              l2_flush_req
);

  arb_state_t state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 1 = L1I was served last
  logic       pend_d_q, pend_d_d;
  logic       pend_i_q, pend_i_d;
  logic       req_q, req_d;
  logic       nd, ni;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b0;
      pend_d_q   <= 1'b0;
      pend_i_q   <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      pend_d_q   <= pend_d_d;
      pend_i_q   <= pend_i_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    nd = pend_d_q | l1d_req_valid;
    ni = pend_i_q | l1i_req_valid;

    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    pend_d_d      = nd;
    pend_i_d      = ni;
    req_d         = req_q;
    l1d_rsp_valid = 1'b0;
    l1i_rsp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ties go to whichever side was not served last.
        if (nd && ni) begin
          state_d = last_gnt_q ? GNT_L1D : GNT_L1I;
          req_d   = 1'b1;
        end else if (nd) begin
          state_d = GNT_L1D;
          req_d   = 1'b1;
        end else if (ni) begin
          state_d = GNT_L1I;
          req_d   = 1'b1;
        end
      end
      GNT_L1D: begin
        last_gnt_d = 1'b0;
        pend_d_d   = 1'b0;   // strobes from the owner during a grant are dropped
        if (l2_req_ack) req_d = 1'b0;
        if (l2_rsp_valid) begin
          req_d         = 1'b0;
          state_d       = IDLE;
          l1d_rsp_valid = 1'b1;
        end
      end
      GNT_L1I: begin
        last_gnt_d = 1'b1;
        pend_i_d   = 1'b0;
        if (l2_req_ack) req_d = 1'b0;
        if (l2_rsp_valid) begin
          req_d         = 1'b0;
          state_d       = IDLE;
          l1i_rsp_valid = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign l2_req_valid      = req_q;
  assign l2_req_addr       = (state_q == GNT_L1I) ? l1i_req_addr   : l1d_req_addr;
  assign l2_req_opcode     = (state_q == GNT_L1I) ? l1i_req_opcode : l1d_req_opcode;
  assign l2_req_store_data = l1d_req_store_data;
  assign l1_rsp_load_data  = l2_rsp_load_data;

  l1_flush_seq u_flush_seq (
    .clk              (clk),
    .reset            (reset),
    .flush_req_l1d_i  (flush_req_l1d),
    .flush_req_l1i_i  (flush_req_l1i),
    .l1d_flush_cmpl_i (l1d_flush_complete),
    .l1i_flush_cmpl_i (l1i_flush_complete),
    .in_flush_mode_o  (in_flush_mode),
    .l2_flush_req_o   (l2_flush_req)
  );

`ifdef L1_ARB_TRACE_EN
  always @(posedge clk) begin
    if (reset && l1d_rsp_valid)
      $display("[%0t] l1_arb: L1D transfer complete", $time);
    if (reset && l1i_rsp_valid)
      $display("[%0t] l1_arb: L1I transfer complete addr=%h", $time, l2_req_addr);
  end
`else
`endif

endmodule

// File: tb/tb_core_l1_mem_arbiter.sv
module tb_core_l1_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         l1d_req_valid;
  logic [31:0]  l1d_req_addr;
  logic [3:0]   l1d_req_opcode;
  logic [127:0] l1d_req_store_data;
  logic         l1d_rsp_valid;
  logic         l1i_req_valid;
  logic [31:0]  l1i_req_addr;
  logic [3:0]   l1i_req_opcode;
  logic         l1i_rsp_valid;
  logic         l2_req_valid;
  logic         l2_req_ack;
  logic [31:0]  l2_req_addr;
  logic [3:0]   l2_req_opcode;
  logic [127:0] l2_req_store_data;
  logic         l2_rsp_valid;
  logic [127:0] l2_rsp_load_data;
  logic [127:0] l1_rsp_load_data;
  logic         flush_req_l1d;
  logic         flush_req_l1i;
  logic         l1d_flush_complete;
  logic         l1i_flush_complete;
  logic         in_flush_mode;
  logic         l2_flush_req;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  core_l1_mem_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .l1d_req_valid      (l1d_req_valid),
    .l1d_req_addr       (l1d_req_addr),
    .l1d_req_opcode     (l1d_req_opcode),
    .l1d_req_store_data (l1d_req_store_data),
    .l1d_rsp_valid      (l1d_rsp_valid),
    .l1i_req_valid      (l1i_req_valid),
    .l1i_req_addr       (l1i_req_addr),
    .l1i_req_opcode     (l1i_req_opcode),
    .l1i_rsp_valid      (l1i_rsp_valid),
    .l2_req_valid       (l2_req_valid),
    .l2_req_ack         (l2_req_ack),
    .l2_req_addr        (l2_req_addr),
    .l2_req_opcode      (l2_req_opcode),
    .l2_req_store_data  (l2_req_store_data),
    .l2_rsp_valid       (l2_rsp_valid),
    .l2_rsp_load_data   (l2_rsp_load_data),
    .l1_rsp_load_data   (l1_rsp_load_data),
    .flush_req_l1d      (flush_req_l1d),
    .flush_req_l1i      (flush_req_l1i),
    .l1d_flush_complete (l1d_flush_complete),
    .l1i_flush_complete (l1i_flush_complete),
    .in_flush_mode      (in_flush_mode),
    .l2_flush_req       (l2_flush_req)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle L2 response in the current cycle and check routing.
  task automatic respond(input string tag, input logic exp_d, input logic exp_i);
    l2_rsp_valid     = 1'b1;
    l2_rsp_load_data = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
    #1;
    chk({tag, "_rspd"}, l1d_rsp_valid, exp_d);
    chk({tag, "_rspi"}, l1i_rsp_valid, exp_i);
    step();
    l2_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    l1d_req_valid = 0; l1d_req_addr = 32'h0; l1d_req_opcode = 4'h0;
    l1d_req_store_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    l1i_req_valid = 0; l1i_req_addr = 32'h0; l1i_req_opcode = 4'h0;
    l2_req_ack = 0; l2_rsp_valid = 0; l2_rsp_load_data = 128'h0;
    flush_req_l1d = 0; flush_req_l1i = 0;
    l1d_flush_complete = 0; l1i_flush_complete = 0;

    // Reset state
    step(); step();
    chk("rst_l2v", l2_req_valid, 1'b0);
    chk("rst_fm",  in_flush_mode, 1'b0);
    chk("rst_l2f", l2_flush_req, 1'b0);
    reset = 1'b1;
    step();
    chk("idle_l2v", l2_req_valid, 1'b0);

    // Flush both: i-complete then d-complete three cycles later
    flush_req_l1d = 1; flush_req_l1i = 1;
    step();
    flush_req_l1d = 0; flush_req_l1i = 0;
    chk("fl_mode1", in_flush_mode, 1'b1);
    chk("fl_l2f0", l2_flush_req, 1'b0);
    l1i_flush_complete = 1;
    step();
    l1i_flush_complete = 0;
    chk("fl_l2f1", l2_flush_req, 1'b0);
    step(); step();
    chk("fl_l2f2", l2_flush_req, 1'b0);
    l1d_flush_complete = 1;
    step();
    l1d_flush_complete = 0;
    chk("fl_pulse", l2_flush_req, 1'b1);
    step();
    chk("fl_pulse_end", l2_flush_req, 1'b0);
    chk("fl_mode_hold", in_flush_mode, 1'b1);

    // Single L1D transfer (arbitration continues during flush mode)
    l1d_req_valid = 1; l1d_req_addr = 32'h1000; l1d_req_opcode = 4'd4;
    #1;
    chk("t1_v0", l2_req_valid, 1'b0);
    chk("t1_sd", l2_req_store_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    step();
    l1d_req_valid = 0;
    chk("t1_v1", l2_req_valid, 1'b1);
    chk("t1_addr", l2_req_addr, 32'h1000);
    chk("t1_opc", l2_req_opcode, 4'd4);
    step(); step();
    l2_req_ack = 1;
    step();
    l2_req_ack = 0;
    chk("t1_v_ackd", l2_req_valid, 1'b0);
    step(); step();
    l2_rsp_valid = 1; l2_rsp_load_data = 128'hDEAD_BEEF;
    #1;
    chk("t1_rspd", l1d_rsp_valid, 1'b1);
    chk("t1_rspi", l1i_rsp_valid, 1'b0);
    chk("t1_ldata", l1_rsp_load_data, 128'hDEAD_BEEF);
    step();
    // Back in IDLE: a stray response must route nowhere
    #1;
    chk("t1_idle_rspd", l1d_rsp_valid, 1'b0);
    chk("t1_idle_rspi", l1i_rsp_valid, 1'b0);
    l2_rsp_valid = 0;
    step();
    chk("t1_idle_v", l2_req_valid, 1'b0);

    // Tie after reset-state last_gnt=0: L1I first, then L1D from pending
    l1d_req_addr = 32'h2000; l1d_req_opcode = 4'd1;
    l1i_req_addr = 32'h3000; l1i_req_opcode = 4'd2;
    l1d_req_valid = 1; l1i_req_valid = 1;
    step();
    l1d_req_valid = 0; l1i_req_valid = 0;
    chk("t2_v", l2_req_valid, 1'b1);
    chk("t2_addr_i", l2_req_addr, 32'h3000);
    chk("t2_opc_i", l2_req_opcode, 4'd2);
    respond("t2_i", 1'b0, 1'b1);
    chk("t2_idle_v", l2_req_valid, 1'b0);
    step();
    chk("t2_vd", l2_req_valid, 1'b1);
    chk("t2_addr_d", l2_req_addr, 32'h2000);
    respond("t2_d", 1'b1, 1'b0);

    // Back-to-back ties: L1I, L1D, L1I
    l1d_req_valid = 1; l1i_req_valid = 1;
    step();
    l1d_req_valid = 0; l1i_req_valid = 0;
    chk("t3_g1", l2_req_addr, 32'h3000);
    respond("t3_g1", 1'b0, 1'b1);
    l1d_req_valid = 1; l1i_req_valid = 1;
    step();
    l1d_req_valid = 0; l1i_req_valid = 0;
    chk("t3_g2", l2_req_addr, 32'h2000);
    chk("t3_g2v", l2_req_valid, 1'b1);
    respond("t3_g2", 1'b1, 1'b0);
    step();
    chk("t3_g3", l2_req_addr, 32'h3000);
    chk("t3_g3v", l2_req_valid, 1'b1);

    // Asynchronous reset mid-transfer (GNT_L1I) with an L1D strobe pending
    l1d_req_valid = 1;
    step();
    l1d_req_valid = 0;
    chk("t6_pre_v", l2_req_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_v", l2_req_valid, 1'b0);
    chk("t6_fm", in_flush_mode, 1'b0);
    chk("t6_mux", l2_req_addr, 32'h2000);
    step();
    reset = 1'b1;
    step(); step();
    chk("t6_no_pend", l2_req_valid, 1'b0);

    // Flush L1I only: one completion suffices
    flush_req_l1i = 1;
    step();
    flush_req_l1i = 0;
    chk("t5_mode", in_flush_mode, 1'b1);
    chk("t5_l2f0", l2_flush_req, 1'b0);
    l1i_flush_complete = 1;
    step();
    l1i_flush_complete = 0;
    chk("t5_pulse", l2_flush_req, 1'b1);
    step();
    chk("t5_pulse_end", l2_flush_req, 1'b0);
    chk("t5_mode_hold", in_flush_mode, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
